sram_1rw1r_resp: RTL and testbench
==================================

// Module: sram_1rw1r_resp
// PURPOSE
//  Synthesizable responder for the active-low SRAM macro interface (csb/web/wmask/addr/din -> dout).
//  Stands in for one 32x512 1rw1r macro behind the cache-array wrappers, in simulation and FPGA builds.
//  Port 0 is read/write; port 1 is read-only. Both have 1-cycle registered read latency.
//  After reset, an optional clear sequencer zero-fills the array before it accepts accesses.
// PARAMETERS
//  DATA_W      32   word width, bits; must be a multiple of 8
//  ADDR_W      9    address width; DEPTH = 2**ADDR_W words
//  CLEAR_INIT  1    1: zero-fill all words after reset; 0: ready immediately, contents undefined
// PORTS
//  clock    in   1          rising-edge clock for both ports and the sequencer
//  reset    in   1          synchronous, active-high
//  csb0     in   1          port 0 chip select, active low
//  web0     in   1          port 0 write enable, active low (0=write, 1=read)
//  wmask0   in   DATA_W/8   port 0 byte write mask; bit i enables din0[8i+7:8i]
//  addr0    in   ADDR_W     port 0 word address
//  din0     in   DATA_W     port 0 write data
//  dout0    out  DATA_W     port 0 read data, registered
//  csb1     in   1          port 1 chip select, active low (read only)
//  addr1    in   ADDR_W     port 1 word address
//  dout1    out  DATA_W     port 1 read data, registered
//  busy     out  1          1 while the clear sequencer runs; all accesses are ignored
//  coll     out  1          registered 1-cycle pulse: same-address write0/read1 collision
// BEHAVIOUR
//  Reset: dout0=0, dout1=0, coll=0. busy=1 if CLEAR_INIT=1, else busy=0. Clear pointer = 0.
//  FSM: CLEAR -> READY. Reset always enters CLEAR (CLEAR_INIT=1) or READY (CLEAR_INIT=0).
//   CLEAR: one word per cycle, ptr 0..DEPTH-1, written to all-zeros. busy=1.
//          After ptr==DEPTH-1 is written: busy=0 and the FSM enters READY on the next cycle.
//          A clear takes exactly DEPTH cycles after reset deasserts.
//   READY: stays in READY until the next reset. Reset in mid-clear restarts the clear at ptr=0.
//  Accesses are sampled at the clock edge only in READY. During CLEAR, csb0/csb1 are ignored,
//   no user write lands, and dout0/dout1 hold their values.
//  Port 0 read (csb0=0, web0=1): dout0 <= mem[addr0] at the sampling edge.
//   Data is visible for the whole next cycle (latency 1).
//  Port 0 write (csb0=0, web0=0): for each byte i with wmask0[i]=1, mem[addr0] byte i <= din0 byte i.
//   Masked bytes are unchanged. wmask0=0 is a legal no-op write. dout0 holds (no write-through).
//  Port 1 read (csb1=0): dout1 <= mem[addr1] at the sampling edge, latency 1.
//  Deselected port (csb=1): its dout holds its last value indefinitely.
//  Collision: port 0 write and port 1 read to the same address in the same cycle.
//   dout1 returns the OLD word (read-before-write). The write completes normally.
//   coll=1 in the following cycle only; otherwise coll=0.
//  Read0/read1 to the same address in the same cycle: both return the same word, coll=0.
//  Back-to-back write then read of the same address on consecutive cycles returns the new data.
//  Addresses are full-range: no out-of-range case exists, and addresses do not wrap.
// TESTING
//  1. reset 1 cycle, CLEAR_INIT=1 -> busy=1 for exactly 512 cycles; then read0 of addr 0x1FF gives dout0=0 next cycle.
//  2. write0 addr 0x005 din 0xDEADBEEF wmask 4'hF; read0 0x005 next cycle -> dout0=0xDEADBEEF one cycle after the read.
//  3. write0 addr 0x005 din 0x11223344 wmask 4'b0101 over 0xDEADBEEF; read1 0x005 -> dout1=0xDE22BE44.
//  4. same cycle: write0 0x010 din 0xA5A5A5A5, read1 0x010 (old 0) -> dout1=0, coll=1 one cycle; next read1 -> 0xA5A5A5A5.
//  5. reset asserted at clear ptr=100 -> busy stays 1; clear restarts at 0 and busy falls 512 cycles after reset deasserts.
//  6. csb0=0 write during busy=1 to 0x020 din 0xFFFFFFFF -> ignored; read0 0x020 after READY returns 0; dout0/dout1 hold.

Source files
------------

// File: rtl/sram_1rw1r_resp.sv
// ---------------------------------------------------------------------------
// sram_1rw1r_resp
//
// Synthesizable behavioural stand-in for a 1rw1r SRAM macro with the usual
// active-low control interface. Port 0 reads or writes with a byte mask.
// Port 1 is read only. Both ports have one cycle of registered read latency.
// When CLEAR_INIT is set, a sequencer zero-fills every word after reset and
// all user accesses are ignored until it finishes.
//
// Ports
//   clock   : rising-edge clock for both ports and the clear sequencer
//   reset   : synchronous, active-high
//   csb0    : port 0 chip select, active low
//   web0    : port 0 write enable, active low (0 = write, 1 = read)
//   wmask0  : port 0 byte write mask, bit i enables din0[8i+7:8i]
//   addr0   : port 0 word address
//   din0    : port 0 write data
//   dout0   : port 0 registered read data
//   csb1    : port 1 chip select, active low
//   addr1   : port 1 word address
//   dout1   : port 1 registered read data
//   busy    : high while the clear sequencer runs
//   coll    : one-cycle pulse after a same-address write0/read1 pair
// ---------------------------------------------------------------------------
module sram_1rw1r_resp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int CLEAR_INIT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [DATA_W/8-1:0]   wmask0,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [DATA_W-1:0]     din0,
  output logic [DATA_W-1:0]     dout0,
  input  logic                  csb1,
  input  logic [ADDR_W-1:0]     addr1,
  output logic [DATA_W-1:0]     dout1,
  output logic                  busy,
  output logic                  coll
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NBYTE = DATA_W / 8;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b01,
    ST_READY = 2'b10
  } state_t;

  // State the FSM leaves reset in (and recovers to from an illegal encoding)
  localparam state_t ST_INIT = (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                busy_q;
  logic [DATA_W-1:0]   dout0_q, dout1_q;
  logic                coll_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                clear_we_s;
  logic                acc_en_s;
  logic                wr0_s;
  logic                rd0_s;
  logic                rd1_s;
  logic                coll_d;

  // FSM state register, clear pointer and busy flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      busy_q  <= (CLEAR_INIT != 0);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      // busy tracks the state being entered so it drops together with READY
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  // FSM next-state logic: CLEAR walks the pointer to the last word, READY is terminal
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // FSM outputs: which agent owns the array this cycle (none while in reset)
  always_comb begin
    clear_we_s = 1'b0;
    acc_en_s   = 1'b0;
    if (reset) begin
      clear_we_s = 1'b0;
      acc_en_s   = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: clear_we_s = 1'b1;
        ST_READY: acc_en_s   = 1'b1;
        default: begin
          clear_we_s = 1'b0;
          acc_en_s   = 1'b0;
        end
      endcase
    end
  end

  // Port request decode, qualified by READY
  always_comb begin
    wr0_s  = acc_en_s & ~csb0 & ~web0;
    rd0_s  = acc_en_s & ~csb0 &  web0;
    rd1_s  = acc_en_s & ~csb1;
    coll_d = wr0_s & rd1_s & (addr0 == addr1);
  end

  // Array write: clear sequencer zero-fill or masked port 0 byte writes
  always_ff @(posedge clock) begin
    if (clear_we_s) begin
      mem_q[ptr_q] <= '0;
    end else if (wr0_s) begin
      for (int b = 0; b < NBYTE; b++) begin
        if (wmask0[b]) begin
          mem_q[addr0][8*b +: 8] <= din0[8*b +: 8];
        end
      end
    end
  end

  // Registered read data and collision flag; the non-blocking array read
  // gives port 1 the pre-write word on a same-address collision
  always_ff @(posedge clock) begin
    if (reset) begin
      dout0_q <= '0;
      dout1_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      if (rd0_s) begin
        dout0_q <= mem_q[addr0];
      end
      if (rd1_s) begin
        dout1_q <= mem_q[addr1];
      end
      coll_q <= coll_d;
    end
  end

  assign dout0 = dout0_q;
  assign dout1 = dout1_q;
  assign busy  = busy_q;
  assign coll  = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_resp.sv
// ---------------------------------------------------------------------------
// tb_sram_1rw1r_resp
//
// Self-checking bench for sram_1rw1r_resp (default parameters). A word-array
// model plus a clear counter predicts every output after every clock edge;
// directed scenarios also pin the model and DUT against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sram_1rw1r_resp;

  localparam int DEPTH = 512;

  logic        clock;
  logic        reset;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout0, dout1;
  logic        busy, coll;

  int checks;
  int errors;

  // reference model
  logic [31:0] mm [DEPTH];
  int          clr_cnt;
  logic [31:0] e_d0, e_d1;
  logic        e_coll;

  sram_1rw1r_resp dut (
    .clock  (clock),
    .reset  (reset),
    .csb0   (csb0),
    .web0   (web0),
    .wmask0 (wmask0),
    .addr0  (addr0),
    .din0   (din0),
    .dout0  (dout0),
    .csb1   (csb1),
    .addr1  (addr1),
    .dout1  (dout1),
    .busy   (busy),
    .coll   (coll)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the memory's rules for one rising edge to the model
  task automatic model_edge();
    logic [31:0] w;
    if (reset) begin
      e_d0 = 32'h0; e_d1 = 32'h0; e_coll = 1'b0; clr_cnt = 0;
    end else if (clr_cnt < DEPTH) begin
      mm[clr_cnt] = 32'h0;
      clr_cnt++;
      e_coll = 1'b0;
    end else begin
      if (!csb1) e_d1 = mm[addr1];
      if (!csb0 && web0) e_d0 = mm[addr0];
      e_coll = (!csb0 && !web0 && !csb1 && addr0 == addr1);
      if (!csb0 && !web0) begin
        w = mm[addr0];
        for (int b = 0; b < 4; b++) if (wmask0[b]) w[8*b +: 8] = din0[8*b +: 8];
        mm[addr0] = w;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output at negedge
  task automatic step(input logic r, input logic c0, input logic w0, input logic [3:0] m,
                      input logic [8:0] a0, input logic [31:0] d,
                      input logic c1, input logic [8:0] a1);
    reset = r; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d;
    csb1 = c1; addr1 = a1;
    model_edge();
    @(posedge clock);
    @(negedge clock);
    chk("busy",  {31'h0, busy},  {31'h0, (clr_cnt < DEPTH)});
    chk("coll",  {31'h0, coll},  {31'h0, e_coll});
    chk("dout0", dout0, e_d0);
    chk("dout1", dout1, e_d1);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b1, 9'h0);
  endtask

  // Pin both the DUT and the model against a hand-computed literal
  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] model,
                     input logic [31:0] lit);
    chk({name, "_dut"}, act, lit);
    chk({name, "_model"}, model, lit);
  endtask

  // Count non-reset edges until busy falls, bounded
  task automatic count_clear(input string name, input int expect_n);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (busy && n < 2000);
    chk(name, n, expect_n);
  endtask

  initial begin
    logic [31:0] h0, h1;
    checks = 0; errors = 0; clr_cnt = 0;
    e_d0 = 32'h0; e_d1 = 32'h0; e_coll = 1'b0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    reset = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 9'h0;
    din0 = 32'h0; csb1 = 1'b1; addr1 = 9'h0;
    @(negedge clock);

    // 1: reset state, clear length, read of the last word
    step(1'b1, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b1, 9'h0);
    pin("reset_busy", {31'h0, busy}, {31'h0, (clr_cnt < DEPTH)}, 32'h1);
    count_clear("clear_len", 512);
    step(1'b0, 1'b0, 1'b1, 4'h0, 9'h1FF, 32'h0, 1'b1, 9'h0);
    pin("rd_1ff", dout0, e_d0, 32'h0);

    // 2: full write then read
    step(1'b0, 1'b0, 1'b0, 4'hF, 9'h005, 32'hDEADBEEF, 1'b1, 9'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 9'h005, 32'h0, 1'b1, 9'h0);
    pin("wr_rd", dout0, e_d0, 32'hDEADBEEF);

    // 3: partial byte write, read back on port 1
    step(1'b0, 1'b0, 1'b0, 4'b0101, 9'h005, 32'h11223344, 1'b1, 9'h0);
    step(1'b0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h005);
    pin("mask_wr", dout1, e_d1, 32'hDE22BE44);

    // 4: same-address collision returns old word and pulses coll
    step(1'b0, 1'b0, 1'b0, 4'hF, 9'h010, 32'hA5A5A5A5, 1'b0, 9'h010);
    pin("coll_old", dout1, e_d1, 32'h0);
    pin("coll_pulse", {31'h0, coll}, {31'h0, e_coll}, 32'h1);
    step(1'b0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 9'h010);
    pin("coll_new", dout1, e_d1, 32'hA5A5A5A5);
    pin("coll_drop", {31'h0, coll}, {31'h0, e_coll}, 32'h0);

    // same-address dual read: both ports see one word, no collision
    step(1'b0, 1'b0, 1'b1, 4'h0, 9'h005, 32'h0, 1'b0, 9'h005);
    pin("dual_rd0", dout0, e_d0, 32'hDE22BE44);
    pin("dual_rd1", dout1, e_d1, 32'hDE22BE44);

    // 5 and 6: reset mid-clear restarts; accesses during busy are ignored
    step(1'b1, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b1, 9'h0);
    for (int i = 0; i < 100; i++) idle();
    step(1'b1, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b1, 9'h0);
    h0 = dout0; h1 = dout1;
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 4'hF, 9'h020, 32'hFFFFFFFF, 1'b0, 9'h010);
    pin("busy_hold0", dout0, e_d0, 32'h0);
    chk("busy_hold0_prev", dout0, h0);
    chk("busy_hold1_prev", dout1, h1);
    count_clear("reclear_len", 508);
    step(1'b0, 1'b0, 1'b1, 4'h0, 9'h020, 32'h0, 1'b1, 9'h0);
    pin("busy_wr_ignored", dout0, e_d0, 32'h0);

    // randomized traffic on a small address window to force collisions
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1499) == 0),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
           4'($urandom), 9'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) == 0), 9'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
